// File: rtl/smem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : smem_arbiter
// Purpose  : Two-master arbiter for the single-port, word-addressed main
//            memory (smem). Master 0 is the RV32I core, master 1 the
//            debug/loader port. One access is granted per clock; read data
//            returns one cycle later with a per-master valid strobe. A master
//            may lock the memory for back-to-back accesses (e.g. RMW), bounded
//            by MAX_LOCK cycles while the other master waits.
// Ports    : clk, reset                       - clock, sync active-high reset
//            mX_req/we/lock/addr/wdata (in)   - master X request
//            mX_gnt (comb), mX_rvalid/rdata   - master X response
//            mem_addr/din/we (out), mem_dout  - smem interface
// Revision : 1.0 - initial release
// ============================================================================
module smem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_LOCK   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // lock_cnt value at which the current locked grant is the last one allowed
    localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

    owner_t            owner_q, owner_d;
    logic              rr_last_q, rr_last_d;
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              init_q;              // high for the cycle following reset
    logic              yield_q, yield_d;    // lock just expired: waiter wins tie

    logic              w_blocked;
    logic              w_win_m0, w_win_m1, w_gnt;
    logic              w_win_we, w_win_lock, w_other_req;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    // Grants and strobes are silenced in the reset cycle and the one after it.
    assign w_blocked = reset | init_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_win_m0 = 1'b0;
        w_win_m1 = 1'b0;
        if (!w_blocked) begin
            if (owner_q == OWN_M0 && m0_req) begin
                w_win_m0 = 1'b1;
            end else if (owner_q == OWN_M1 && m1_req) begin
                w_win_m1 = 1'b1;
            end else if (m0_req && m1_req) begin
                // After a lock expiry the previous owner is rr_last, so the
                // round-robin pick hands the memory to the waiting master even
                // in fixed-priority mode.
                if (FIXED_PRIO != 0 && !yield_q) begin
                    w_win_m1 = 1'b1;
                end else begin
                    w_win_m0 = rr_last_q;
                    w_win_m1 = ~rr_last_q;
                end
            end else begin
                w_win_m0 = m0_req;
                w_win_m1 = m1_req;
            end
        end
    end

    assign w_gnt       = w_win_m0 | w_win_m1;
    assign w_win_we    = w_win_m1 ? m1_we    : m0_we;
    assign w_win_lock  = w_win_m1 ? m1_lock  : m0_lock;
    assign w_win_addr  = w_win_m1 ? m1_addr  : m0_addr;
    assign w_win_wdata = w_win_m1 ? m1_wdata : m0_wdata;
    assign w_other_req = w_win_m1 ? m0_req   : m1_req;

    assign m0_gnt   = w_win_m0;
    assign m1_gnt   = w_win_m1;
    assign mem_we   = w_gnt & w_win_we;
    assign mem_addr = w_gnt ? w_win_addr : addr_q;
    assign mem_din  = w_gnt ? w_win_wdata : '0;

    assign m0_rvalid = rd_pend_q[0] & ~w_blocked;
    assign m1_rvalid = rd_pend_q[1] & ~w_blocked;
    assign m0_rdata  = m0_rvalid ? mem_dout : '0;
    assign m1_rdata  = m1_rvalid ? mem_dout : '0;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        owner_d    = OWN_NONE;
        rr_last_d  = rr_last_q;
        lock_cnt_d = 4'd0;
        rd_pend_d  = 2'b00;
        addr_d     = addr_q;
        yield_d    = 1'b0;
        if (w_gnt) begin
            rr_last_d = w_win_m1;
            rd_pend_d = w_win_m1 ? {~w_win_we, 1'b0} : {1'b0, ~w_win_we};
            addr_d    = w_win_addr;
            if (w_win_lock) begin
                if (w_other_req && lock_cnt_q == LOCK_LAST) begin
                    // Lock budget used up: drop ownership, hand over next cycle.
                    yield_d = 1'b1;
                end else begin
                    owner_d    = w_win_m1 ? OWN_M1 : OWN_M0;
                    lock_cnt_d = w_other_req ? lock_cnt_q + 4'd1 : 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            rr_last_q  <= 1'b1;
            lock_cnt_q <= 4'd0;
            rd_pend_q  <= 2'b00;
            addr_q     <= '0;
            init_q     <= 1'b1;
            yield_q    <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            addr_q     <= addr_d;
            init_q     <= 1'b0;
            yield_q    <= yield_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_smem_arbiter
// Purpose  : Self-checking bench for smem_arbiter. A round-robin instance is
//            driven cycle by cycle from a vector table against a behavioural
//            smem; a fixed-priority instance shares the same inputs and is
//            checked in its own sequence. Lock and RMW are hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_din, mem_dout;
    logic [7:0]  mem_addr;

    logic        fx_m0_gnt, fx_m0_rvalid, fx_m1_gnt, fx_m1_rvalid, fx_mem_we;
    logic [31:0] fx_m0_rdata, fx_m1_rdata, fx_mem_din, fx_dout;
    logic [7:0]  fx_mem_addr;
    assign fx_dout = '0;

    smem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(0), .MAX_LOCK(15)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    smem_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1), .MAX_LOCK(15)) u_fx (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(fx_m0_gnt), .m0_rvalid(fx_m0_rvalid), .m0_rdata(fx_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(fx_m1_gnt), .m1_rvalid(fx_m1_rvalid), .m1_rdata(fx_m1_rdata),
        .mem_addr(fx_mem_addr), .mem_din(fx_mem_din), .mem_we(fx_mem_we), .mem_dout(fx_dout)
    );

    // Behavioural single-port smem: write on the edge, read data next cycle.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic        q0, w0, l0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        q1, w1, l1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        eg0, eg1, ev0, ev1;
        logic [31:0] er0, er1;
        logic        ewe;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic rst,
        input logic q0, input logic w0, input logic l0, input logic [7:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic l1, input logic [7:0] a1, input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic ev0, input logic ev1,
        input logic [31:0] er0, input logic [31:0] er1, input logic ewe);
        vec_t v;
        v.rst = rst;
        v.q0 = q0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
        v.er0 = er0; v.er1 = er1; v.ewe = ewe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(
        input logic rst,
        input logic q0, input logic w0, input logic l0, input logic [7:0] a0, input logic [31:0] d0,
        input logic q1, input logic w1, input logic l1, input logic [7:0] a1, input logic [31:0] d1);
        reset = rst;
        m0_req = q0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0,0,0,8'h00,0, 0,0,0,8'h00,0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table rows: one per clock cycle; rvalid/rdata refer to the
        // previous row's grant.
        //            rst  q0 w0 l0 a0     d0            q1 w1 l1 a1     d1            g0 g1 v0 v1 rd0           rd1           we
        vecs.push_back(mk(1, 1,0,0,8'h01,32'h0,          1,1,0,8'h05,32'h11111111, 0,0,0,0,32'h0,        32'h0,        0)); // reset
        vecs.push_back(mk(0, 1,0,0,8'h01,32'h0,          1,1,0,8'h05,32'h11111111, 0,0,0,0,32'h0,        32'h0,        0)); // post-reset
        vecs.push_back(mk(0, 1,1,0,8'h01,32'hA0A00001,   0,0,0,8'h00,32'h0,        1,0,0,0,32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 0,0,0,8'h00,32'h0,          1,1,0,8'h02,32'hB0B00002, 0,1,0,0,32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 1,1,0,8'h05,32'hDEADBEEF,   0,0,0,8'h00,32'h0,        1,0,0,0,32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 1,0,0,8'h05,32'h0,          0,0,0,8'h00,32'h0,        1,0,0,0,32'h0,        32'h0,        0)); // single read
        vecs.push_back(mk(0, 0,0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,        0,0,1,0,32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(0, 1,0,0,8'h01,32'h0,          0,0,0,8'h00,32'h0,        1,0,0,0,32'h0,        32'h0,        0)); // read then reset
        vecs.push_back(mk(1, 1,0,0,8'h01,32'h0,          1,1,0,8'h01,32'h77777777, 0,0,0,0,32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 1,0,0,8'h01,32'h0,          1,1,0,8'h01,32'h77777777, 0,0,0,0,32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 1,0,0,8'h01,32'h0,          1,0,0,8'h02,32'h0,        1,0,0,0,32'h0,        32'h0,        0)); // RR: M0 first
        vecs.push_back(mk(0, 1,0,0,8'h05,32'h0,          1,0,0,8'h02,32'h0,        0,1,1,0,32'hA0A00001, 32'h0,        0));
        vecs.push_back(mk(0, 1,0,0,8'h05,32'h0,          1,0,0,8'h01,32'h0,        1,0,0,1,32'h0,        32'hB0B00002, 0));
        vecs.push_back(mk(0, 1,0,0,8'h02,32'h0,          1,0,0,8'h01,32'h0,        0,1,1,0,32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(0, 1,0,0,8'h02,32'h0,          0,0,0,8'h00,32'h0,        1,0,0,1,32'h0,        32'hA0A00001, 0));
        vecs.push_back(mk(0, 0,0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,        0,0,1,0,32'hB0B00002, 32'h0,        0));
        vecs.push_back(mk(0, 0,0,0,8'h00,32'h0,          1,1,0,8'hFF,32'h00000042, 0,1,0,0,32'h0,        32'h0,        1)); // top address
        vecs.push_back(mk(0, 1,0,0,8'hFF,32'h0,          0,0,0,8'h00,32'h0,        1,0,0,0,32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0,0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,        0,0,1,0,32'h00000042, 32'h0,        0));

        drive(1, 0,0,0,8'h00,0, 0,0,0,8'h00,0);
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].q0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
                  vecs[i].q1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("row%0d.m0_gnt", i),    32'(m0_gnt),    32'(vecs[i].eg0));
            chk($sformatf("row%0d.m1_gnt", i),    32'(m1_gnt),    32'(vecs[i].eg1));
            chk($sformatf("row%0d.m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].ev0));
            chk($sformatf("row%0d.m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].ev1));
            chk($sformatf("row%0d.m0_rdata", i),  m0_rdata,       vecs[i].er0);
            chk($sformatf("row%0d.m1_rdata", i),  m1_rdata,       vecs[i].er1);
            chk($sformatf("row%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].ewe));
            step();
        end

        // Lock starvation bound: m1 first makes itself the last winner so that
        // m0 wins the opening tie, then m0 holds a locked request.
        drive(0, 0,0,0,8'h00,0, 1,1,0,8'h10,32'h00000100);
        @(negedge clk);
        chk("lock_prep.m1_gnt", 32'(m1_gnt), 32'd1);
        step();
        for (int c = 1; c <= 16; c++) begin
            drive(0, 1,0,1,8'h10,0, 1,0,0,8'h20,0);
            @(negedge clk);
            chk($sformatf("lock_c%0d.m0_gnt", c), 32'(m0_gnt), (c <= 15) ? 32'd1 : 32'd0);
            chk($sformatf("lock_c%0d.m1_gnt", c), 32'(m1_gnt), (c == 16) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        step();

        // Read-modify-write of 0x10 by m0 under lock; m1 reads 0x10 meanwhile.
        drive(0, 1,0,1,8'h10,0, 1,0,0,8'h10,0);
        @(negedge clk);
        chk("rmw_rd.m0_gnt", 32'(m0_gnt), 32'd1);
        step();
        drive(0, 1,0,1,8'h10,0, 1,0,0,8'h10,0);
        @(negedge clk);
        chk("rmw_hold.m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rmw_hold.m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rmw_hold.m0_rdata", m0_rdata, 32'h00000100);
        step();
        drive(0, 1,1,0,8'h10,32'h00000101, 1,0,0,8'h10,0);
        @(negedge clk);
        chk("rmw_wr.m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rmw_wr.m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rmw_wr.mem_we", 32'(mem_we), 32'd1);
        step();
        drive(0, 0,0,0,8'h00,0, 1,0,0,8'h10,0);
        @(negedge clk);
        chk("rmw_after.m1_gnt", 32'(m1_gnt), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("rmw_after.m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("rmw_after.m1_rdata", m1_rdata, 32'h00000101);
        chk("rmw_after.m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("idle.mem_din", mem_din, 32'h0);
        chk("idle.mem_addr_hold", 32'(mem_addr), 32'h10);
        step();

        // Fixed priority instance: m1 wins three ties, then m0 once m1 drops.
        for (int c = 1; c <= 4; c++) begin
            if (c <= 3) drive(0, 1,0,0,8'h01,0, 1,0,0,8'h02,0);
            else        drive(0, 1,0,0,8'h01,0, 0,0,0,8'h00,0);
            @(negedge clk);
            chk($sformatf("fixed_c%0d.m0_gnt", c), 32'(fx_m0_gnt), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("fixed_c%0d.m1_gnt", c), 32'(fx_m1_gnt), (c <= 3) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smem_arbiter.md
Name: smem_arbiter

Overview:
Two-master arbiter that shares the single-port word-addressed main memory (smem) between the RV32I core (master 0) and a debug/loader port (master 1, e.g. a switch/UART program loader).
- Grants at most one access per clock and drives the memory address, data and write enable from the winner.
- Returns read data one cycle later with a per-master valid strobe.
- Supports a lock so a master can hold the memory for back-to-back accesses, for example a read-modify-write sequence.

Parameters:
ADDR_W, 8, memory word-address width (smem depth = 2**ADDR_W words)
DATA_W, 32, memory data width
FIXED_PRIO, 0, 0 = round-robin; 1 = master 1 always wins a simultaneous request
MAX_LOCK, 15, maximum consecutive cycles a locked master keeps ownership while the other master waits (4-bit counter)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  master 0 access request; held until granted
m0_we  in  1  master 0 write (1) / read (0)
m0_lock  in  1  master 0 requests continued ownership after this grant
m0_addr  in  ADDR_W  master 0 word address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 access accepted this cycle (combinational)
m0_rvalid  out  1  master 0 read data valid (registered)
m0_rdata  out  DATA_W  master 0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata  in  as m0  master 1 request signals
m1_gnt, m1_rvalid, m1_rdata  out  as m0  master 1 response signals
mem_addr  out  ADDR_W  to smem addr
mem_din  out  DATA_W  to smem din
mem_we  out  1  to smem we
mem_dout  in  DATA_W  from smem dout; valid the cycle after the address is presented

Behaviour:
- State: owner register (NONE, M0, M1), last-winner bit rr_last, lock counter lock_cnt[3:0], and pending-read registers rd_pend[1:0].
- Reset: owner=NONE, rr_last=1 (so master 0 wins first tie), lock_cnt=0, rd_pend=0. All gnt and rvalid outputs are 0, and mem_we=0, in the reset cycle and the cycle after it.
- Arbitration (combinational, each cycle):
  - If owner=Mx and mx_req=1, Mx wins.
  - Else, if only one master requests, it wins.
  - Else, if both request: with FIXED_PRIO=1, M1 wins; with FIXED_PRIO=0, the master other than rr_last wins.
  - If neither requests, there is no grant.
- The winner's gnt=1. mem_addr, mem_din and mem_we come from the winner. With no winner: mem_we=0, mem_addr holds its last value, mem_din=0.
- The loser's gnt=0; the loser must hold its request stable.
- Clock edge with a grant:
  - rr_last <= winner.
  - rd_pend[winner] <= ~we.
  - The other rd_pend bit <= 0.
- Read latency:
  - mx_rvalid = rd_pend[x], asserted exactly 1 cycle after a granted read. One cycle wide per read.
  - mx_rdata = mem_dout when rvalid=1. Otherwise mx_rdata = 0.
  - Back-to-back reads give back-to-back rvalid pulses.
- Lock:
  - If the winner has lock=1, owner <= winner.
  - lock_cnt increments when the owner is granted while the other master is requesting; otherwise lock_cnt <= 0.
  - When lock_cnt reaches MAX_LOCK, or the owner drops lock or req: owner <= NONE and lock_cnt <= 0. A waiting master then wins the next cycle regardless of rr_last.
- Writes produce no rvalid. Write completes on the grant edge.
- Simultaneous events: a write and a read to the same address cannot occur in one cycle (one grant per cycle). A read granted the cycle after a write to the same address returns the new data.
- Reset asserted mid-operation: any pending rvalid is suppressed, owner and lock are cleared, and a write presented in the reset cycle is not performed (mem_we=0).
- Address width: the upper bits of the CPU byte address are truncated by the master. The arbiter does no address arithmetic and has no wrap logic.

Test Plan:
- Single read: m0 reads addr 0x05 after a write of 0xDEADBEEF → m0_gnt same cycle, m0_rvalid=1 next cycle, m0_rdata=0xDEADBEEF, m1_rvalid stays 0.
- Round-robin: both masters issue continuous reads (FIXED_PRIO=0) → grants alternate M0, M1, M0, M1 starting with M0 after reset. Each rvalid is routed to the correct master.
- Fixed priority: FIXED_PRIO=1, both request for 3 cycles → M1 granted all 3 cycles, then M0 is granted in cycle 4 once M1 drops req.
- Lock/starvation: m0 holds lock=1 with continuous req while m1 requests → m0 granted for 15 consecutive cycles, m1 granted on cycle 16. Read-modify-write by m0 (read 0x10, write 0x10+1 while locked) is not interleaved by m1.
- Write then read: m1 writes 0x00000042 to 0xFF (top address), then m0 reads 0xFF the next cycle → m0_rdata=0x00000042. The write produces no rvalid.
- Reset mid-read: reset asserted on the cycle after a granted read → rvalid stays 0, the next grant after reset goes to M0 on a tie, and the write in the reset cycle leaves memory unchanged.
